// File: rtl/wb_queue.sv
// Writeback queue between execute and the register-file write port.
// In-order drain, youngest-first bypass lookup over pending entries.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_reg,
  input  logic [31:0]                in_data,
  input  logic                       wb_stall,
  output logic                       RegWrite,
  output logic [4:0]                 Write_register,
  output logic [31:0]                Write_data,
  input  logic [4:0]                 lookup_reg,
  output logic                       lookup_hit,
  output logic [31:0]                lookup_data,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]    reg_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] idx;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = rst_n & ~full;
  // r0 writes are architecturally void, so they are consumed but never stored
  assign push     = in_valid & in_ready & (in_reg != 5'd0);
  assign RegWrite = ~empty & ~wb_stall;
  assign pop      = RegWrite;
  assign pending  = count;

  assign Write_register = empty ? 5'd0  : reg_q[head];
  assign Write_data     = empty ? 32'd0 : data_q[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[tail]  <= in_reg;
      data_q[tail] <= in_data;
    end
  end

  // Scan oldest to youngest so the youngest match is left standing;
  // the head is skipped when it commits this cycle.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = 32'd0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && !(i == 0 && pop) &&
          (lookup_reg != 5'd0) && (reg_q[idx] == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue.
// Inputs change 1ns after rising edges; outputs sampled mid-cycle.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_data = '0;
  logic        wb_stall = 1'b0;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [4:0]  lookup_reg = '0;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_reg(in_reg),
    .in_data(in_data),
    .wb_stall(wb_stall),
    .RegWrite(RegWrite),
    .Write_register(Write_register),
    .Write_data(Write_data),
    .lookup_reg(lookup_reg),
    .lookup_hit(lookup_hit),
    .lookup_data(lookup_data),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_reg   = '0;
    in_data  = '0;
  endtask

  initial begin
    #2;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_wreg", 32'(Write_register), 32'd0);
    check("rst_wdata", Write_data, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("idle_ready", 32'(in_ready), 32'd1);

    // single write
    push(5'd5, 32'hDEADBEEF);
    #1;
    check("single_rw", 32'(RegWrite), 32'd1);
    check("single_reg", 32'(Write_register), 32'd5);
    check("single_data", Write_data, 32'hDEADBEEF);
    step();
    check("single_rw_after", 32'(RegWrite), 32'd0);
    check("single_pend_after", 32'(pending), 32'd0);

    // r0 request is consumed without a write
    push(5'd0, 32'h1234);
    for (int i = 0; i < 5; i++) begin
      check("zero_pend", 32'(pending), 32'd0);
      check("zero_rw", 32'(RegWrite), 32'd0);
      step();
    end

    // fill under stall, then drain
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
    check("full_pend", 32'(pending), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_rw", 32'(RegWrite), 32'd0);
    check("full_head", 32'(Write_register), 32'd1);
    lookup_reg = 5'd3;
    #1;
    check("full_lk_hit", 32'(lookup_hit), 32'd1);
    check("full_lk_data", lookup_data, 32'h103);
    lookup_reg = 5'd0;
    wb_stall = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_rw", 32'(RegWrite), 32'd1);
      check("drain_reg", 32'(Write_register), 32'(i));
      check("drain_data", Write_data, 32'h100 + 32'(i));
      step();
    end
    check("drain_pend", 32'(pending), 32'd0);
    check("drain_rw_end", 32'(RegWrite), 32'd0);

    // youngest match wins, head excluded while committing
    wb_stall = 1'b1;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    lookup_reg = 5'd7;
    #1;
    check("lk_hit", 32'(lookup_hit), 32'd1);
    check("lk_data", lookup_data, 32'hB);
    lookup_reg = 5'd0;
    #1;
    check("lk_zero_hit", 32'(lookup_hit), 32'd0);
    check("lk_zero_data", lookup_data, 32'd0);
    lookup_reg = 5'd9;
    #1;
    check("lk_miss", 32'(lookup_hit), 32'd0);
    lookup_reg = 5'd7;
    wb_stall = 1'b0;
    #1;
    check("lk_drain1_hit", 32'(lookup_hit), 32'd1);
    check("lk_drain1_data", lookup_data, 32'hB);
    step();
    check("lk_drain2_rw", 32'(RegWrite), 32'd1);
    check("lk_drain2_hit", 32'(lookup_hit), 32'd0);
    check("lk_drain2_data", lookup_data, 32'd0);
    step();
    check("lk_empty", 32'(pending), 32'd0);

    // in-flight request is not searched
    lookup_reg = 5'd3;
    in_valid = 1'b1;
    in_reg   = 5'd3;
    in_data  = 32'h33;
    #1;
    check("inflight_hit", 32'(lookup_hit), 32'd0);
    step();
    in_valid = 1'b0;
    in_reg   = '0;
    check("inflight_rw", 32'(RegWrite), 32'd1);
    check("inflight_reg", 32'(Write_register), 32'd3);
    check("inflight_self", 32'(lookup_hit), 32'd0);
    lookup_reg = 5'd0;
    step();

    // back-to-back pushes, pointers wrap
    in_valid = 1'b1;
    in_reg   = 5'd1;
    in_data  = 32'hC0DE_0000;
    for (int i = 0; i < 10; i++) begin
      step();
      check("wrap_rw", 32'(RegWrite), 32'd1);
      check("wrap_reg", 32'(Write_register), 32'(i + 1));
      check("wrap_data", Write_data, 32'hC0DE_0000 + 32'(i));
      check("wrap_pend", 32'(pending), 32'd1);
      if (i < 9) begin
        in_reg  = 5'(i + 2);
        in_data = 32'hC0DE_0000 + 32'(i + 1);
      end else begin
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
      end
    end
    step();
    check("wrap_end", 32'(pending), 32'd0);

    // asynchronous reset during drain
    wb_stall = 1'b1;
    push(5'd10, 32'hAA);
    push(5'd11, 32'hBB);
    push(5'd12, 32'hCC);
    check("mid_pend", 32'(pending), 32'd3);
    wb_stall = 1'b0;
    lookup_reg = 5'd11;
    #1;
    check("mid_rw", 32'(RegWrite), 32'd1);
    check("mid_lk", 32'(lookup_hit), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rw", 32'(RegWrite), 32'd0);
    check("mid_rst_reg", 32'(Write_register), 32'd0);
    check("mid_rst_data", Write_data, 32'd0);
    check("mid_rst_pend", 32'(pending), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_lk", 32'(lookup_hit), 32'd0);
    check("mid_rst_lkd", lookup_data, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_rw", 32'(RegWrite), 32'd0);
      check("post_rst_pend", 32'(pending), 32'd0);
    end
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
